// File: rtl/md_sched_if.sv
// Pipeline-side bundle for the multiply/divide scheduler.
// The E stage drives the request and the D stage drives the hazard hint.
// The scheduler returns HI/LO, busy, start and the stall request.
interface md_sched_if;
  logic        md_valid_E;
  logic [2:0]  md_op_E;
  logic [31:0] md_a_E;
  logic [31:0] md_b_E;
  logic        md_use_D;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        start_o;
  logic        md_stall_o;

  modport master (
    output md_valid_E, md_op_E, md_a_E, md_b_E, md_use_D,
    input  hi_o, lo_o, busy_o, start_o, md_stall_o
  );

  modport slave (
    input  md_valid_E, md_op_E, md_a_E, md_b_E, md_use_D,
    output hi_o, lo_o, busy_o, start_o, md_stall_o
  );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler with the architectural HI/LO registers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | unit free; mthi/mtlo write directly, mult/div may start
// ST_RUN   | result held in pending regs, count runs down to commit
//
// The result is computed in the start cycle and parked in pending registers.
// The busy window only models the architectural latency.
// HI/LO are committed at the edge where the count reaches its terminal value.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  md
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]  state;
  logic [3:0]  count;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic        busy;
  logic        is_mul;
  logic        is_div;
  logic        is_signed;
  logic        start;
  logic        wr_hi;
  logic        wr_lo;
  logic        last_cycle;

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign busy       = (state == ST_RUN);
  assign last_cycle = busy && (count == 4'd1);

  // Opcode decode; reserved and none fall through as no-ops.
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (md.md_op_E)
      OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU: begin is_mul = 1'b1;                   end
      OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  begin is_div = 1'b1;                   end
      default:  begin                                   end
    endcase
  end

  // Requests from E are only honoured while idle; a legal pipeline never
  // presents one while busy because the D-stage stall holds it back.
  assign start = md.md_valid_E && (is_mul || is_div) && !busy;
  assign wr_hi = md.md_valid_E && (md.md_op_E == OP_MTHI) && !busy;
  assign wr_lo = md.md_valid_E && (md.md_op_E == OP_MTLO) && !busy;

  // 64-bit product; sign- or zero-extending first makes one multiplier
  // serve both mult and multu.
  always_comb begin
    a_ext = is_signed ? {{32{md.md_a_E[31]}}, md.md_a_E} : {32'd0, md.md_a_E};
    b_ext = is_signed ? {{32{md.md_b_E[31]}}, md.md_b_E} : {32'd0, md.md_b_E};
    prod  = a_ext * b_ext;
  end

  // Sign-magnitude divide: truncating quotient, remainder follows dividend.
  // 0x80000000 / -1 falls out naturally since its magnitude fits unsigned.
  always_comb begin
    neg_a = is_signed && md.md_a_E[31];
    neg_b = is_signed && md.md_b_E[31];
    mag_a = neg_a ? (32'd0 - md.md_a_E) : md.md_a_E;
    mag_b = neg_b ? (32'd0 - md.md_b_E) : md.md_b_E;
    den   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag = mag_a / den;
    r_mag = mag_a % den;
    quot  = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem   = neg_a ? (32'd0 - r_mag) : r_mag;
  end

  // Select the value to park; divide by zero re-parks current HI/LO.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    if (is_mul) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (md.md_b_E != 32'd0) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  // Scheduler FSM with a down-counter terminating at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            count <= is_mul ? MULT_CNT : DIV_CNT;
          end
        end
        ST_RUN: begin
          if (count == 4'd1) begin
            state <= ST_IDLE;
            count <= 4'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

  // Capture the operation result at the start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else if (start) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
    end
  end

  // Architectural HI/LO: commit on the last busy cycle, or direct move when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (last_cycle) begin
      hi_q <= pend_hi;
      lo_q <= pend_lo;
    end else begin
      if (wr_hi) hi_q <= md.md_a_E;
      if (wr_lo) lo_q <= md.md_a_E;
    end
  end

  assign md.hi_o       = hi_q;
  assign md.lo_o       = lo_q;
  assign md.busy_o     = busy;
  assign md.start_o    = start;
  assign md.md_stall_o = md.md_use_D && (busy || start);

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed steps followed by random operations.
// Expected HI/LO values come from a longint arithmetic reference model.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;

  md_sched_if bus ();

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int illegal_cnt = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Reference: architectural result {HI, LO} of one instruction.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin p = sa * sb; return p; end
      3'd2: begin p = ua * ub; return p; end
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd5: return {a, lo};
      3'd6: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  // One instruction through E, checking start/stall/busy/HI/LO cycle by cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic vld, input logic use_d);
    logic [63:0] r;
    logic is_md;
    int n;
    r = model(op, a, b, exp_hi, exp_lo);
    is_md = vld && (op >= 3'd1) && (op <= 3'd4);
    n = (op == 3'd1 || op == 3'd2) ? MULT_N : DIV_N;
    @(negedge clk);
    bus.md_valid_E = vld;
    bus.md_op_E    = op;
    bus.md_a_E     = a;
    bus.md_b_E     = b;
    bus.md_use_D   = use_d;
    #1;
    chk1("start_o", bus.start_o, is_md);
    chk1("stall_start", bus.md_stall_o, use_d && is_md);
    @(posedge clk);
    #1;
    bus.md_valid_E = 1'b0;
    bus.md_op_E    = 3'd0;
    if (is_md) begin
      for (int i = 0; i < n; i++) begin
        chk1("busy_run", bus.busy_o, 1'b1);
        chk1("stall_run", bus.md_stall_o, use_d);
        chk("hi_hold", bus.hi_o, exp_hi);
        chk("lo_hold", bus.lo_o, exp_lo);
        @(posedge clk);
        #1;
      end
    end
    if (vld) begin
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    chk1("busy_done", bus.busy_o, 1'b0);
    chk1("stall_done", bus.md_stall_o, 1'b0);
    chk("hi_done", bus.hi_o, exp_hi);
    chk("lo_done", bus.lo_o, exp_lo);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        vld, ud;
    logic [63:0] r;
    int          sel, n;

    reset = 1'b0;
    bus.md_valid_E = 1'b0;
    bus.md_op_E    = 3'd0;
    bus.md_a_E     = 32'd0;
    bus.md_b_E     = 32'd0;
    bus.md_use_D   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi_o, 32'd0);
    chk("rst_lo", bus.lo_o, 32'd0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    chk("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo_o, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
    chk("multu_hi", bus.hi_o, 32'h0000_0001);
    chk("multu_lo", bus.lo_o, 32'hFFFF_FFFE);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("div_lo", bus.lo_o, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi_o, 32'hFFFF_FFFF);

    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    chk("divu_lo", bus.lo_o, 32'h7FFF_FFFC);
    chk("divu_hi", bus.hi_o, 32'h0000_0001);

    // mflo held in D for the whole divide.
    issue(3'd3, 32'd100, 32'd7, 1'b1, 1'b1);
    chk("mflo_quot", bus.lo_o, 32'd14);
    bus.md_use_D = 1'b0;

    issue(3'd5, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    chk("mthi", bus.hi_o, 32'h1234_5678);

    // mtlo presented while busy: must be ignored.
    r = model(3'd3, 32'd1000, 32'd3, exp_hi, exp_lo);
    @(negedge clk);
    bus.md_valid_E = 1'b1;
    bus.md_op_E    = 3'd3;
    bus.md_a_E     = 32'd1000;
    bus.md_b_E     = 32'd3;
    @(posedge clk);
    #1;
    bus.md_op_E = 3'd6;
    bus.md_a_E  = 32'hDEAD_BEEF;
    #1;
    chk1("start_busy", bus.start_o, 1'b0);
    if (bus.md_valid_E && bus.busy_o && bus.md_op_E >= 3'd1 && bus.md_op_E <= 3'd6) begin
      illegal_cnt++;
      $display("note: HI/LO instruction issued while busy (illegal in a real pipeline)");
    end
    @(posedge clk);
    #1;
    bus.md_valid_E = 1'b0;
    bus.md_op_E    = 3'd0;
    n = 0;
    while (bus.busy_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk1("illegal_busy_end", bus.busy_o, 1'b0);
    chk("illegal_wait", n, DIV_N - 1);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk("illegal_lo", bus.lo_o, 32'd333);
    chk("illegal_hi", bus.hi_o, 32'd1);
    chk("illegal_flag", illegal_cnt, 1);

    issue(3'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    issue(3'd6, 32'd6, 32'd0, 1'b1, 1'b0);
    issue(3'd3, 32'd77, 32'd0, 1'b1, 1'b0);
    chk("divz_hi", bus.hi_o, 32'd5);
    chk("divz_lo", bus.lo_o, 32'd6);
    issue(3'd4, 32'd77, 32'd0, 1'b1, 1'b0);
    chk("divuz_lo", bus.lo_o, 32'd6);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    chk("ovf_lo", bus.lo_o, 32'h8000_0000);
    chk("ovf_hi", bus.hi_o, 32'd0);

    issue(3'd7, 32'd9, 32'd9, 1'b1, 1'b1);
    issue(3'd1, 32'd9, 32'd9, 1'b0, 1'b1);
    issue(3'd0, 32'd9, 32'd9, 1'b1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      op  = 3'($urandom_range(0, 7));
      vld = ($urandom_range(0, 9) != 0);
      ud  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 9)) ^ {32{b[31]}};
      issue(op, a, b, vld, ud);
    end

    // Asynchronous reset in the 3rd busy cycle of a mult.
    issue(3'd5, 32'hAAAA_0001, 32'd0, 1'b1, 1'b0);
    issue(3'd6, 32'h5555_0002, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    bus.md_valid_E = 1'b1;
    bus.md_op_E    = 3'd1;
    bus.md_a_E     = 32'd3;
    bus.md_b_E     = 32'd4;
    @(posedge clk);
    #1;
    bus.md_valid_E = 1'b0;
    bus.md_op_E    = 3'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk1("pre_rst_busy", bus.busy_o, 1'b1);
    reset = 1'b0;
    #1;
    chk1("mid_rst_busy", bus.busy_o, 1'b0);
    chk("mid_rst_hi", bus.hi_o, 32'd0);
    chk("mid_rst_lo", bus.lo_o, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk1("post_rst_busy", bus.busy_o, 1'b0);
    chk("post_rst_hi", bus.hi_o, 32'd0);
    chk("post_rst_lo", bus.lo_o, 32'd0);

    issue(3'd2, 32'd6, 32'd7, 1'b1, 1'b1);
    chk("post_rst_mult", bus.lo_o, 32'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide scheduler for the pipelined MIPS core.
- Sits beside the ALU in the E stage and owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo from E and holds the result for a fixed latency.
- Raises a stall request that the hazard unit ORs with its Tuse/Tnew stall, keeping any HI/LO-touching instruction in D until the unit is free.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10: busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- md_valid_E  input  1  E-stage instruction is real, not a bubble.
- md_op_E  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- md_a_E  input  32  forwarded rs value.
- md_b_E  input  32  forwarded rt value.
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- hi_o  output  32  architectural HI.
- lo_o  output  32  architectural LO.
- busy_o  output  1  operation in flight (registered).
- start_o  output  1  combinational: md_valid_E and md_op_E in 1..4 and not busy_o.
- md_stall_o  output  1  combinational: md_use_D and (busy_o or start_o).

Behaviour:
- Reset (reset=0, asynchronous): hi_o=0, lo_o=0, busy_o=0, count=0, pending HI/LO=0. An in-flight operation is discarded and HI/LO are not updated.
- States:
  - IDLE (busy_o=0).
  - RUN (busy_o=1, count=1..15).
- IDLE -> RUN on a clock edge with start_o=1:
  - mult/multu: count<=MULT_CYCLES.
  - div/divu: count<=DIV_CYCLES.
  - Operands are consumed at that edge and the result is computed into pending registers.
- Computation rules:
  - mult: signed 32x32->64.
  - multu: unsigned 32x32->64.
  - In both cases pending_hi={prod[63:32]}, pending_lo=prod[31:0].
  - div: signed; quotient truncates toward zero; remainder takes the sign of the dividend.
  - divu: unsigned.
  - For div/divu: pending_lo=quotient, pending_hi=remainder.
  - Divide by zero: pending = current hi_o/lo_o, so HI/LO are unchanged.
  - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- RUN: count decrements each edge. At the edge where count==1: hi_o<=pending_hi, lo_o<=pending_lo, busy_o<=0, count<=0 -> IDLE. busy_o is therefore high for exactly N cycles, and the new HI/LO are visible in the cycle after the last busy cycle.
- mthi/mtlo: apply only when md_valid_E=1 and busy_o=0; written at the next edge (hi_o<=md_a_E or lo_o<=md_a_E). Ignored while busy.
- Any start/mthi/mtlo arriving while busy_o=1 is ignored. This cannot occur in a legal pipeline because the stall holds the instruction in D; the bench flags it as an error.
- md_valid_E=0: no action regardless of md_op_E.
- mfhi/mflo read hi_o/lo_o combinationally in E. This is safe because the stall guarantees busy_o=0 by the time they reach E.
- md_stall_o must depend on neither hi_o nor lo_o. There is no combinational path from md_a_E or md_b_E to any output.

Test Plan:
- Reset release, then mult a=0xFFFFFFFF, b=2 -> busy_o high for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu of the same operands -> LO=0x7FFFFFFC, HI=1.
- Start div, then hold md_use_D=1 (mflo in D) throughout -> md_stall_o=1 in the start cycle and all 10 busy cycles, 0 in the first IDLE cycle, and mflo then reads the quotient.
- mthi 0x12345678 while idle -> hi_o=0x12345678 next cycle. mtlo issued while busy -> lo_o is unaffected, and the error is flagged. div by zero with HI=5, LO=6 -> HI/LO remain 5/6.
- Assert reset=0 in the 3rd busy cycle of a mult -> busy_o=0 and HI=LO=0 immediately; the old result never appears after reset releases.
